sram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit SRAM controller. It sits between the requesters and the controller's request interface: port 0 is the LSU and port 1 is a secondary master (boot loader or DMA). It accepts one held request at a time, issues a single-cycle launch to the controller and waits for its acknowledge. It then returns a registered one-cycle ack with read data, or an error if the controller never answers.

---
 rtl/sram_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter/sequencer in front of the shared 32-bit SRAM controller: one launch, one ack per transaction.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 wins every tie.
module sram_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_p0_req,
    input  logic        i_p0_we,
    input  logic [31:0] i_p0_addr,
    input  logic [31:0] i_p0_wdata,
    input  logic [3:0]  i_p0_bmask,
    output logic        o_p0_ack,
    output logic        o_p0_err,
    output logic [31:0] o_p0_rdata,

    input  logic        i_p1_req,
    input  logic        i_p1_we,
    input  logic [31:0] i_p1_addr,
    input  logic [31:0] i_p1_wdata,
    input  logic [3:0]  i_p1_bmask,
    output logic        o_p1_ack,
    output logic        o_p1_err,
    output logic [31:0] o_p1_rdata,

    output logic [17:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    output logic        o_mem_wren,
    output logic        o_mem_rden,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,

    output logic        o_busy,
    output logic        o_grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // The counter holds the number of WAIT cycles already spent, so the last legal one is TIMEOUT_CYCLES-1.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we;

    logic        w_any_req;
    logic        w_win;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_bmask;
    logic        w_unused;

    assign w_any_req = i_p0_req | i_p1_req;
    assign w_unused  = ^{i_p0_addr[31:19], i_p0_addr[1:0], i_p1_addr[31:19], i_p1_addr[1:0]};

`ifdef SRAM_ARB_RR_EN
    logic r_last;

    // A tie goes to the port that did not win last time; a lone requester always wins.
    assign w_win = (i_p0_req & i_p1_req) ? ~r_last : i_p1_req;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last <= 1'b1;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_last <= w_win;
        end
    end
`else
    assign w_win = ~i_p0_req;
`endif

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel_we    = i_p0_we;
        w_sel_addr  = i_p0_addr;
        w_sel_wdata = i_p0_wdata;
        w_sel_bmask = i_p0_bmask;
        if (w_win) begin
            w_sel_we    = i_p1_we;
            w_sel_addr  = i_p1_addr;
            w_sel_wdata = i_p1_wdata;
            w_sel_bmask = i_p1_bmask;
        end
    end

    // Launch strobes are the only outputs decoded straight from the state register.
    assign o_mem_wren = (r_state == ST_ISSUE) &&  r_we;
    assign o_mem_rden = (r_state == ST_ISSUE) && !r_we;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, whatever the statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_we        <= 1'b0;
            o_mem_addr  <= 18'd0;
            o_mem_wdata <= 32'd0;
            o_mem_bmask <= 4'd0;
            o_grant     <= 1'b0;
            o_busy      <= 1'b0;
            o_p0_ack    <= 1'b0;
            o_p0_err    <= 1'b0;
            o_p0_rdata  <= 32'd0;
            o_p1_ack    <= 1'b0;
            o_p1_err    <= 1'b0;
            o_p1_rdata  <= 32'd0;
        end else begin
            o_p0_ack <= 1'b0;
            o_p0_err <= 1'b0;
            o_p1_ack <= 1'b0;
            o_p1_err <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_we        <= w_sel_we;
                        o_mem_addr  <= {w_sel_addr[18:2], 1'b0};
                        o_mem_wdata <= w_sel_wdata;
                        o_mem_bmask <= w_sel_bmask;
                        o_grant     <= w_win;
                        r_cnt       <= 8'd0;
                        o_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // An ack in the final WAIT cycle still beats the timeout.
                    if (i_mem_ack || r_cnt == LP_CNT_LAST) begin
                        if (o_grant) begin
                            o_p1_ack <= 1'b1;
                            o_p1_err <= ~i_mem_ack;
                            if (!r_we) o_p1_rdata <= i_mem_ack ? i_mem_rdata : 32'd0;
                        end else begin
                            o_p0_ack <= 1'b1;
                            o_p0_err <= ~i_mem_ack;
                            if (!r_we) o_p0_rdata <= i_mem_ack ? i_mem_rdata : 32'd0;
                        end
                        r_state <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter; the model predicts each transaction's timeline arithmetically.
module tb_sram_port_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_p0_req, i_p0_we, i_p1_req, i_p1_we;
    logic [31:0] i_p0_addr, i_p0_wdata, i_p1_addr, i_p1_wdata;
    logic [3:0]  i_p0_bmask, i_p1_bmask;
    logic        o_p0_ack, o_p0_err, o_p1_ack, o_p1_err;
    logic [31:0] o_p0_rdata, o_p1_rdata;
    logic [17:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren, o_mem_rden;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic        o_busy, o_grant;

    int          checks = 0;
    int          errors = 0;
    bit          m_last = 1'b1;
    logic [31:0] exp_rd [2] = '{32'd0, 32'd0};

    always #5 clk = ~clk;

    sram_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_p0_req(i_p0_req), .i_p0_we(i_p0_we), .i_p0_addr(i_p0_addr),
        .i_p0_wdata(i_p0_wdata), .i_p0_bmask(i_p0_bmask),
        .o_p0_ack(o_p0_ack), .o_p0_err(o_p0_err), .o_p0_rdata(o_p0_rdata),
        .i_p1_req(i_p1_req), .i_p1_we(i_p1_we), .i_p1_addr(i_p1_addr),
        .i_p1_wdata(i_p1_wdata), .i_p1_bmask(i_p1_bmask),
        .o_p1_ack(o_p1_ack), .o_p1_err(o_p1_err), .o_p1_rdata(o_p1_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .o_mem_wren(o_mem_wren), .o_mem_rden(o_mem_rden),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
        .o_busy(o_busy), .o_grant(o_grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input bit p);
        return p ? o_p1_ack : o_p0_ack;
    endfunction

    function automatic logic err_of(input bit p);
        return p ? o_p1_err : o_p0_err;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_grant"}, o_grant, 0);
        check({tag, "_wren"}, o_mem_wren, 0);
        check({tag, "_rden"}, o_mem_rden, 0);
        check({tag, "_addr"}, o_mem_addr, 0);
        check({tag, "_wdata"}, o_mem_wdata, 0);
        check({tag, "_bmask"}, o_mem_bmask, 0);
        check({tag, "_acks"}, {o_p0_ack, o_p1_ack, o_p0_err, o_p1_err}, 0);
        check({tag, "_rd0"}, o_p0_rdata, 0);
        check({tag, "_rd1"}, o_p1_rdata, 0);
    endtask

    // Called at a negedge while the DUT is idle; returns at the first idle negedge after the round.
    // ack_at = cycle (relative to the arbitration cycle T) in which the controller acks; out of range means none.
    task automatic round(input bit r0, input bit r1, input bit we0, input bit we1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [3:0] m0, input logic [3:0] m1,
                         input int ack_at, input logic [31:0] mem_rd, input int drop_at);
        bit          win, we, err, accepted;
        logic [31:0] a, wd;
        logic [3:0]  bm;
        logic [17:0] exp_addr;
        int          resp, last;

        if (r0 && r1) begin
`ifdef SRAM_ARB_RR_EN
            win = ~m_last;
`else
            win = 1'b0;
`endif
        end else begin
            win = r1;
        end
        m_last = win;

        we       = win ? we1 : we0;
        a        = win ? a1 : a0;
        wd       = win ? d1 : d0;
        bm       = win ? m1 : m0;
        exp_addr = 18'((a & 32'h0007_FFFC) >> 1);
        accepted = (ack_at >= 2) && (ack_at <= TO + 1);
        err      = !accepted;
        resp     = accepted ? ack_at + 1 : TO + 2;
        last     = (ack_at + 1 > resp + 1) ? ack_at + 1 : resp + 1;

        i_p0_req = r0; i_p0_we = we0; i_p0_addr = a0; i_p0_wdata = d0; i_p0_bmask = m0;
        i_p1_req = r1; i_p1_we = we1; i_p1_addr = a1; i_p1_wdata = d1; i_p1_bmask = m1;

        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            check("wren", o_mem_wren, (k == 1) && we);
            check("rden", o_mem_rden, (k == 1) && !we);
            if (k <= resp) begin
                check("mem_addr", o_mem_addr, exp_addr);
                check("mem_wdata", o_mem_wdata, wd);
                check("mem_bmask", o_mem_bmask, bm);
                check("busy", o_busy, 1);
                check("grant", o_grant, win);
            end else begin
                check("busy_idle", o_busy, 0);
            end
            if (k == resp) begin
                if (!we) exp_rd[win] = err ? 32'd0 : mem_rd;
                check("ack_win", ack_of(win), 1);
                check("err_win", err_of(win), err);
            end else begin
                check("ack_win_idle", ack_of(win), 0);
                check("err_win_idle", err_of(win), 0);
            end
            check("ack_other", {ack_of(!win), err_of(!win)}, 0);
            check("rdata0", o_p0_rdata, exp_rd[0]);
            check("rdata1", o_p1_rdata, exp_rd[1]);

            i_mem_ack   = (k == ack_at);
            i_mem_rdata = (k == ack_at) ? mem_rd : $urandom;
            if (k == drop_at) begin
                if (win) i_p1_req = 1'b0;
                else     i_p0_req = 1'b0;
            end
            if (k == resp) begin
                i_p0_req = 1'b0;
                i_p1_req = 1'b0;
            end
        end
        i_mem_ack = 1'b0;
    endtask

    initial begin
        bit r0, r1;
        int ack_at;

        i_reset_n = 1'b0;
        i_p0_req = 0; i_p0_we = 0; i_p0_addr = 0; i_p0_wdata = 0; i_p0_bmask = 0;
        i_p1_req = 0; i_p1_we = 0; i_p1_addr = 0; i_p1_wdata = 0; i_p1_bmask = 0;
        i_mem_ack = 0; i_mem_rdata = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        i_reset_n = 1'b1;
        @(negedge clk);

        // Port 0 write, controller acks at T+3.
        round(1, 0, 1, 0, 32'h0000_2008, 32'h0, 32'hDEAD_BEEF, 32'h0, 4'hF, 4'h0, 3, 32'h1234_5678, 0);
        // Port 1 read, data at T+4.
        round(0, 1, 0, 0, 32'h0, 32'h0000_2008, 32'h0, 32'h0, 4'h0, 4'hF, 4, 32'hDEAD_BEEF, 0);
        // Three tied read rounds.
        for (int i = 0; i < 3; i++)
            round(1, 1, 0, 0, 32'h100 + i * 4, 32'h200 + i * 4, 0, 0, 4'hF, 4'hF, 4, $urandom, 0);
        // Timeout, then a stray controller ack at T+20.
        round(1, 0, 0, 0, 32'h0004_0010, 0, 0, 0, 4'h3, 4'h0, 20, 32'hCAFE_F00D, 0);
        // Ack in the last legal WAIT cycle is accepted.
        round(0, 1, 0, 0, 0, 32'h0007_FFFC, 0, 0, 0, 4'h1, TO + 1, 32'h0BAD_CAFE, 0);
        // Port 0 drops req during WAIT.
        round(1, 0, 1, 0, 32'h0000_0040, 0, 32'h5555_AAAA, 0, 4'hC, 4'h0, 3, 32'h0, 2);

        // Reset during WAIT of a read.
        i_p0_req = 1; i_p0_we = 0; i_p0_addr = 32'h0000_0800; i_p0_bmask = 4'hF;
        repeat (3) @(negedge clk);
        #2 i_reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        i_p0_req = 0;
        exp_rd = '{32'd0, 32'd0};
        m_last = 1'b1;
        @(negedge clk);
        i_reset_n = 1'b1;
        i_mem_ack = 1'b1;
        @(negedge clk);
        check("post_reset_ack", {o_p0_ack, o_p1_ack}, 0);
        check("post_reset_busy", o_busy, 0);
        i_mem_ack = 1'b0;
        round(1, 0, 0, 0, 32'h0000_0800, 0, 0, 0, 4'hF, 4'h0, 4, 32'h7777_1111, 0);

        // Randomised rounds.
        for (int i = 0; i < 24; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            case ($urandom_range(0, 9))
                0:       ack_at = TO + 2;
                1:       ack_at = TO + 1;
                default: ack_at = $urandom_range(2, 7);
            endcase
            round(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom, $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ack_at, $urandom, ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
